mda_pixel_deser: RTL and testbench
==================================

Name: mda_pixel_deser

Overview:
- Deserializer that turns a monochrome MDA video stream back into character-line bytes.
- Samples pixel_in together with hsync and vsync on pixclk and splits each active line into 9-pixel character cells.
- Each cell is packed into an 8-bit char_line plus its 9th-column bit and tagged with column and scanline numbers.
- Results are delivered through a 2-entry valid/ready buffer. The block sits at the video capture/loopback input and checks what the pixel serializer path produces.

Parameters:
- H_BP, 18: pixclk cycles from hsync deassertion to the first active pixel.
- COLS, 80: character cells per active line (max 127).
- V_BP, 4: hsync deassertions from vsync deassertion to the first active scanline.
- LINES, 350: active scanlines per frame (max 511).
- HSYNC_POL, 1: active level of hsync.
- VSYNC_POL, 0: active level of vsync.

Ports:
- pixclk  in  1  pixel clock; all logic is on its rising edge
- rst  in  1  synchronous reset, active-high
- pixel_in  in  1  serial video bit
- hsync  in  1  horizontal sync, polarity set by HSYNC_POL
- vsync  in  1  vertical sync, polarity set by VSYNC_POL
- out_ready  in  1  consumer accepts the head entry
- out_valid  out  1  head entry present
- char_line  out  8  cell pixels 0..7; pixel k maps to bit k
- col9  out  1  cell pixel 8
- col  out  7  cell index, 0..COLS-1
- scanline  out  9  active line index, 0..LINES-1
- frame_start  out  1  one-cycle pulse when active line 0 begins
- locked  out  1  a vsync deassertion has been seen since reset
- overflow  out  1  sticky: a cell was dropped because the buffer was full
- short_line  out  1  sticky: hsync asserted before COLS cells completed

Behaviour:
- Input stage: pixel_in, hsync and vsync are registered together in one stage. All edge detection uses the registered copies, so a pixel and its sync stay aligned.
- Reset:
  - Every output is 0; the buffer is emptied; the H FSM goes to H_IDLE; the V counters clear; locked goes to 0.
  - A reset in mid-line or mid-frame discards the partial cell and all buffered entries.
- Vertical:
  - On vsync deassertion: locked goes to 1, line_cnt goes to 0, v_active goes to 0, and the V_BP countdown starts.
  - The countdown decrements on each hsync deassertion. The hsync deassertion that takes it to 0 starts active line 0 and pulses frame_start in the same cycle that H_BP counting begins.
  - Each later hsync deassertion increments line_cnt.
  - After LINES active lines, v_active goes to 0 and no cells are produced until the next vsync deassertion.
  - While locked is 0, no cells are produced.
- H FSM:
  - H_IDLE: on hsync deassertion go to H_BP and set pix_cnt to 0.
  - H_BP: when pix_cnt reaches H_BP-1, go to H_ACT with sub-cell index 0 and cell index 0.
  - H_ACT, each cycle:
    - Sub-cell index k < 8: the registered pixel is stored at bit k.
    - k = 8: the bit is stored in col9, the cell is pushed if v_active is 1, k returns to 0 and the cell index increments.
    - After cell COLS-1 completes, go to H_DONE.
  - H_DONE: wait for hsync assertion, then go to H_IDLE.
  - hsync asserted in H_BP or H_ACT: go to H_IDLE. If this happens in H_ACT, set short_line and drop the partial cell.
- Latency: out_valid rises 2 pixclk after the 9th pixel of a cell is on pixel_in, provided the buffer was empty.
- Buffer:
  - 2-entry FIFO; each entry holds {char_line, col9, col, scanline}.
  - Outputs show the head entry, and stay stable while out_valid=1 and out_ready=0.
  - Pop happens when out_valid and out_ready are both 1.
  - Push and pop in the same cycle: both succeed, including when the buffer is full, because the pop frees space first.
  - Push while full with no pop: the cell is dropped and overflow is set.
  - overflow and short_line clear only on rst.

Test Plan:
1. Params H_BP=2, COLS=2, V_BP=1, LINES=2, out_ready=1. Stream one frame with cells 0xA5/0, 0x3C/1 on every line.
   -> 4 entries: (0xA5,col9=0,col0,line0), (0x3C,col9=1,col1,line0), then the same pair for line1; frame_start pulses once; locked=1.
2. Same stream with out_ready=0 for a whole line.
   -> out_valid holds entry (0xA5,col0) stable, the second cell is buffered, the next cell sets overflow=1, and the first two are delivered unchanged afterwards.
3. Buffer full, out_ready=1 in the same cycle that a new cell completes.
   -> no drop and overflow stays 0; the next two pops return the 2nd and then the 3rd cell in order.
4. hsync asserted after 13 active pixels of a line with COLS=2.
   -> short_line=1; only cell 0 is output for that line; the next line is captured normally.
5. Video running before any vsync deassertion.
   -> locked=0 and out_valid never asserts. After the vsync deassertion, the first entry has scanline=0.
6. rst asserted for 1 cycle in mid-cell while 1 entry is buffered.
   -> next cycle out_valid=0, overflow=0, locked=0, and no entries appear until the next vsync deassertion.

Source files
------------

// File: rtl/mda_pixel_deser.sv
// Rebuilds MDA character-line bytes from the serial pixel stream and hands them out,
// tagged with column and scanline, through a 2-entry valid/ready buffer.
module mda_pixel_deser #(
    parameter int H_BP      = 18,
    parameter int COLS      = 80,
    parameter int V_BP      = 4,
    parameter int LINES     = 350,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic       pixel_in,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] char_line,
    output logic       col9,
    output logic [6:0] col,
    output logic [8:0] scanline,
    output logic       frame_start,
    output logic       locked,
    output logic       overflow,
    output logic       short_line
);
    // state   | meaning
    // HS_IDLE | waiting for hsync deassertion
    // HS_BP   | back-porch countdown
    // HS_ACT  | shifting pixels into 9-pixel cells
    // HS_DONE | all cells of the line taken, waiting for hsync
    typedef enum logic [1:0] {HS_IDLE, HS_BP, HS_ACT, HS_DONE} h_state_t;

    localparam int BPW = $clog2(H_BP + 1);
    localparam int VBW = $clog2(V_BP + 1);

    h_state_t       h_state, h_nxt;
    logic           pix_r, hs_r, vs_r, hs_d, vs_d;
    logic           hs_on, hs_on_d, vs_on, vs_on_d, hs_fall, vs_fall;
    logic [BPW-1:0] bp_cnt;
    logic [3:0]     sub_idx;
    logic [6:0]     cell_idx;
    logic [7:0]     cell_bits;
    logic           push_req, short_set;
    logic [VBW-1:0] vbp_cnt;
    logic           v_active;
    logic [8:0]     line_cnt;
    logic [24:0]    fifo_mem [2];
    logic           rd_ptr, wr_ptr;
    logic [1:0]     fifo_cnt;
    logic           pop, push_ok;
    logic [24:0]    push_data;

    // Registers reset to the inactive sync levels so a reset never fakes a sync edge.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            pix_r <= 1'b0;
            hs_r  <= ~HSYNC_POL;
            vs_r  <= ~VSYNC_POL;
            hs_d  <= ~HSYNC_POL;
            vs_d  <= ~VSYNC_POL;
        end else begin
            pix_r <= pixel_in;
            hs_r  <= hsync;
            vs_r  <= vsync;
            hs_d  <= hs_r;
            vs_d  <= vs_r;
        end
    end

    assign hs_on   = (hs_r == HSYNC_POL);
    assign hs_on_d = (hs_d == HSYNC_POL);
    assign vs_on   = (vs_r == VSYNC_POL);
    assign vs_on_d = (vs_d == VSYNC_POL);
    assign hs_fall = hs_on_d & ~hs_on;
    assign vs_fall = vs_on_d & ~vs_on;

    always_ff @(posedge pixclk) begin
        if (rst) begin
            locked      <= 1'b0;
            v_active    <= 1'b0;
            line_cnt    <= '0;
            vbp_cnt     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (vs_fall) begin
                locked   <= 1'b1;
                line_cnt <= '0;
                v_active <= 1'b0;
                vbp_cnt  <= VBW'(V_BP);
            end else if (hs_fall) begin
                if (vbp_cnt != '0) begin
                    vbp_cnt <= vbp_cnt - VBW'(1);
                    if (vbp_cnt == VBW'(1)) begin
                        v_active    <= 1'b1;
                        line_cnt    <= '0;
                        frame_start <= 1'b1;
                    end
                end else if (v_active) begin
                    if (line_cnt == 9'(LINES - 1))
                        v_active <= 1'b0;
                    else
                        line_cnt <= line_cnt + 9'd1;
                end
            end
        end
    end

    always_comb begin
        h_nxt     = h_state;
        push_req  = 1'b0;
        short_set = 1'b0;
        case (h_state)
            HS_IDLE: if (hs_fall) h_nxt = HS_BP;
            HS_BP: begin
                if (hs_on)
                    h_nxt = HS_IDLE;
                else if (bp_cnt == '0)
                    h_nxt = HS_ACT;
            end
            HS_ACT: begin
                if (hs_on) begin
                    h_nxt     = HS_IDLE;
                    short_set = 1'b1;
                end else if (sub_idx == 4'd8) begin
                    push_req = v_active;
                    if (cell_idx == 7'(COLS - 1))
                        h_nxt = HS_DONE;
                end
            end
            HS_DONE: if (hs_on) h_nxt = HS_IDLE;
            default: h_nxt = HS_IDLE;
        endcase
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            h_state    <= HS_IDLE;
            bp_cnt     <= '0;
            sub_idx    <= '0;
            cell_idx   <= '0;
            cell_bits  <= '0;
            short_line <= 1'b0;
        end else begin
            h_state <= h_nxt;
            if (short_set)
                short_line <= 1'b1;
            case (h_state)
                HS_IDLE: bp_cnt <= BPW'(H_BP - 1);
                HS_BP: begin
                    bp_cnt   <= bp_cnt - BPW'(1);
                    sub_idx  <= '0;
                    cell_idx <= '0;
                end
                HS_ACT: begin
                    if (sub_idx == 4'd8) begin
                        sub_idx  <= '0;
                        cell_idx <= cell_idx + 7'd1;
                    end else begin
                        cell_bits[sub_idx[2:0]] <= pix_r;
                        sub_idx                 <= sub_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The 9th pixel goes straight from the input register into the entry.
    assign push_data = {cell_bits, pix_r, cell_idx, line_cnt};
    assign out_valid = (fifo_cnt != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push_ok   = push_req & ((fifo_cnt != 2'd2) | pop);
    assign {char_line, col9, col, scanline} = fifo_mem[rd_ptr];

    always_ff @(posedge pixclk) begin
        if (rst) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
            overflow    <= 1'b0;
        end else begin
            if (push_req & ~push_ok)
                overflow <= 1'b1;
            if (push_ok) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mda_pixel_deser.sv
// Scoreboard bench for mda_pixel_deser: line stimulus queues expected entries,
// a negedge monitor pops and compares each handshake.
module tb_mda_pixel_deser;
    localparam int H_BP_T  = 2;
    localparam int COLS_T  = 2;
    localparam int V_BP_T  = 1;
    localparam int LINES_T = 2;

    logic       pixclk, rst, pixel_in, hsync, vsync, out_ready;
    logic       out_valid, col9, frame_start, locked, overflow, short_line;
    logic [7:0] char_line;
    logic [6:0] col;
    logic [8:0] scanline;

    int          n_vec = 0;
    int          n_err = 0;
    int          fs_cnt = 0;
    logic [24:0] exp_q [$];

    mda_pixel_deser #(
        .H_BP(H_BP_T), .COLS(COLS_T), .V_BP(V_BP_T), .LINES(LINES_T),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) dut (
        .pixclk(pixclk), .rst(rst), .pixel_in(pixel_in), .hsync(hsync), .vsync(vsync),
        .out_ready(out_ready), .out_valid(out_valid), .char_line(char_line), .col9(col9),
        .col(col), .scanline(scanline), .frame_start(frame_start), .locked(locked),
        .overflow(overflow), .short_line(short_line)
    );

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Monitor: a handshake seen at negedge completes on the next rising edge.
    initial begin
        logic [24:0] e;
        forever begin
            @(negedge pixclk);
            if (frame_start) fs_cnt++;
            if (out_valid && out_ready && !rst) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_entry: got char=%h col9=%0d col=%0d line=%0d, required none",
                             char_line, col9, col, scanline);
                end else begin
                    e = exp_q.pop_front();
                    if ({char_line, col9, col, scanline} !== e) begin
                        n_err++;
                        $display("FAIL entry: got char=%h col9=%0d col=%0d line=%0d, required char=%h col9=%0d col=%0d line=%0d",
                                 char_line, col9, col, scanline, e[24:17], e[16], e[15:9], e[8:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic p, input logic h, input logic v);
        pixel_in = p;
        hsync    = h;
        vsync    = v;
        @(posedge pixclk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    task automatic vsync_pulse();
        repeat (4) drive(1'b0, 1'b0, 1'b0);
    endtask

    // kind: 1 raise out_ready, 2 check held head/overflow then raise out_ready, 3 pulse rst
    task automatic send_line(input logic [7:0] c0, input logic b0, input logic [7:0] c1,
                             input logic b1, input int npix, input int fp,
                             input bit exp0, input bit exp1, input int line_no,
                             input int act_at, input int kind);
        logic [17:0] pv;
        pv = {b1, c1, b0, c0};
        if (exp0) exp_q.push_back({c0, b0, 7'd0, 9'(line_no)});
        if (exp1) exp_q.push_back({c1, b1, 7'd1, 9'(line_no)});
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        repeat (H_BP_T + 1) drive(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < npix; i++) begin
            if (i == act_at) begin
                if (kind == 2) begin
                    check("held_valid", int'(out_valid), 1);
                    check("held_char", int'(char_line), 8'hA5);
                    check("held_col", int'(col), 0);
                    check("overflow_set", int'(overflow), 1);
                end
                if (kind == 1 || kind == 2) out_ready = 1'b1;
                if (kind == 3) rst = 1'b1;
            end
            drive(pv[i], 1'b0, 1'b1);
            if (i == act_at && kind == 3) begin
                rst = 1'b0;
                check("rst_valid", int'(out_valid), 0);
                check("rst_overflow", int'(overflow), 0);
                check("rst_locked", int'(locked), 0);
                check("rst_short_line", int'(short_line), 0);
            end
        end
        repeat (fp) drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) drive(1'b0, 1'b0, 1'b1);
        repeat (10) drive(1'b0, 1'b0, 1'b1);
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        int fs_base;
        rst = 1'b1; pixel_in = 1'b0; hsync = 1'b0; vsync = 1'b1; out_ready = 1'b1;
        @(posedge pixclk); #2;
        do_reset();
        check("reset_valid", int'(out_valid), 0);
        check("reset_locked", int'(locked), 0);

        // 1: one frame, free-running consumer; third line is past LINES
        fs_base = fs_cnt;
        vsync_pulse();
        send_line(8'hA5, 1'b0, 8'h3C, 1'b1, 18, 2, 1, 1, 0, -1, 0);
        send_line(8'hA5, 1'b0, 8'h3C, 1'b1, 18, 2, 1, 1, 1, -1, 0);
        send_line(8'hA5, 1'b0, 8'h3C, 1'b1, 18, 2, 0, 0, 2, -1, 0);
        drain();
        check("t1_frame_start", fs_cnt - fs_base, 1);
        check("t1_locked", int'(locked), 1);
        check("t1_overflow", int'(overflow), 0);

        // 2: consumer stalled across line 0 and the first cell of line 1
        out_ready = 1'b0;
        vsync_pulse();
        send_line(8'hA5, 1'b0, 8'h3C, 1'b1, 18, 2, 1, 1, 0, -1, 0);
        send_line(8'hA5, 1'b0, 8'h3C, 1'b1, 18, 2, 0, 1, 1, 12, 2);
        send_line(8'hA5, 1'b0, 8'h3C, 1'b1, 18, 2, 0, 0, 2, -1, 0);
        drain();
        check("t2_overflow_sticky", int'(overflow), 1);

        // 3: full buffer popped in the same cycle a new cell lands
        do_reset();
        out_ready = 1'b0;
        vsync_pulse();
        send_line(8'h81, 1'b1, 8'h7E, 1'b0, 18, 2, 1, 1, 0, -1, 0);
        send_line(8'h0F, 1'b0, 8'hF0, 1'b1, 18, 2, 1, 1, 1, 9, 1);
        drain();
        check("t3_overflow", int'(overflow), 0);
        check("t3_short_line", int'(short_line), 0);

        // 4: hsync after 13 active pixels
        fs_base = fs_cnt;
        vsync_pulse();
        send_line(8'hA5, 1'b0, 8'h3C, 1'b1, 13, 0, 1, 0, 0, -1, 0);
        send_line(8'h5A, 1'b1, 8'hC3, 1'b0, 18, 2, 1, 1, 1, -1, 0);
        drain();
        check("t4_short_line", int'(short_line), 1);
        check("t4_frame_start", fs_cnt - fs_base, 1);

        // 6: reset mid-cell with one entry buffered
        out_ready = 1'b0;
        vsync_pulse();
        send_line(8'hA5, 1'b0, 8'h3C, 1'b1, 18, 2, 0, 0, 0, 12, 3);
        out_ready = 1'b1;
        send_line(8'hA5, 1'b0, 8'h3C, 1'b1, 18, 2, 0, 0, 1, -1, 0);
        drain();
        check("t6_locked_after", int'(locked), 0);
        vsync_pulse();
        send_line(8'h99, 1'b1, 8'h66, 1'b0, 18, 2, 1, 1, 0, -1, 0);
        drain();

        // 5: video before any vsync deassertion
        do_reset();
        send_line(8'hA5, 1'b0, 8'h3C, 1'b1, 18, 2, 0, 0, 0, -1, 0);
        send_line(8'hA5, 1'b0, 8'h3C, 1'b1, 18, 2, 0, 0, 1, -1, 0);
        drain();
        check("t5_locked", int'(locked), 0);
        check("t5_valid", int'(out_valid), 0);
        vsync_pulse();
        send_line(8'h12, 1'b1, 8'h34, 1'b1, 18, 2, 1, 1, 0, -1, 0);
        drain();
        check("t5_locked_after", int'(locked), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
